// File: rtl/outbuf_drain.sv
// outbuf_drain: drops the leading SKIP words of each frame, queues the next FRAMELEN words in a show-ahead FIFO
module outbuf_drain #(
    parameter int WORDLEN  = 8,
    parameter int BUFSIZE  = 10,
    parameter int SKIP     = 0,
    parameter int FRAMELEN = 4
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic               in_valid,
    input  logic [WORDLEN-1:0] din,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [WORDLEN-1:0] dout,
    output logic               out_last,
    output logic               empty,
    output logic               full,
    output logic [5:0]         count,
    output logic               busy,
    output logic               overflow
);
    localparam int PW = $clog2(BUFSIZE);
    typedef enum logic [1:0] {ST_IDLE, ST_SKIP, ST_PASS} state_t;
    state_t             state_q, state_d;
    logic [4:0]         skip_q, skip_d;
    logic [7:0]         frame_q, frame_d;
    logic [PW-1:0]      head_q, head_d, tail_q, tail_d;
    logic [5:0]         count_q, count_d;
    logic               overflow_q, overflow_d;
    logic [WORDLEN:0]   mem_q [BUFSIZE];
    logic [WORDLEN:0]   mem_d [BUFSIZE];
    logic               push, pop, last;
    assign out_valid       = count_q != 6'd0;
    assign empty           = !out_valid;
    assign full            = count_q == 6'(BUFSIZE);
    assign {dout, out_last} = mem_q[head_q];
    assign count           = count_q;
    assign busy            = state_q != ST_IDLE;
    assign overflow        = overflow_q;
    always_comb begin
        state_d    = state_q;
        skip_d     = skip_q;
        frame_d    = frame_q;
        overflow_d = overflow_q;
        pop        = out_valid && out_ready;
        last       = frame_q == 8'(FRAMELEN - 1);
        push       = state_q == ST_PASS && in_valid && !start && (!full || pop);
        if (start) begin
            state_d    = SKIP == 0 ? ST_PASS : ST_SKIP;
            skip_d     = 5'(SKIP);
            frame_d    = '0;
            overflow_d = 1'b0;
        end else if (in_valid && state_q == ST_SKIP) begin
            skip_d  = skip_q - 5'd1;
            state_d = skip_q == 5'd1 ? ST_PASS : ST_SKIP;
        end else if (in_valid && state_q == ST_PASS) begin
            // a dropped word still counts toward the frame, so the FSM never waits on a lost last word
            frame_d    = frame_q + 8'd1;
            overflow_d = overflow_q || !push;
            state_d    = last ? ST_IDLE : ST_PASS;
        end
        head_d  = pop ? (head_q == PW'(BUFSIZE - 1) ? '0 : head_q + PW'(1)) : head_q;
        tail_d  = push ? (tail_q == PW'(BUFSIZE - 1) ? '0 : tail_q + PW'(1)) : tail_q;
        count_d = count_q + {5'd0, push} - {5'd0, pop};
        mem_d   = mem_q;
        if (push) mem_d[tail_q] = {din, last};
    end
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            skip_q     <= '0;
            frame_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            mem_q      <= '{default: '0};
        end else begin
            state_q    <= state_d;
            skip_q     <= skip_d;
            frame_q    <= frame_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            mem_q      <= mem_d;
        end
    end
endmodule

// File: tb/tb_outbuf_drain.sv
// tb_outbuf_drain: three differently parameterised instances share one stimulus and are checked against a frame-level model
module tb_outbuf_drain;
    localparam int PB [3] = '{10, 4, 4};
    localparam int PS [3] = '{2, 0, 0};
    localparam int PF [3] = '{4, 6, 3};
    logic       clk = 0, rstn = 0, start = 0, in_valid = 0, out_ready = 0;
    logic [7:0] din = 0;
    logic       ov_w [3], last_w [3], empty_w [3], full_w [3], busy_w [3], ovf_w [3];
    logic [7:0] dout_w [3];
    logic [5:0] cnt_w [3];
    int         total = 0, bad = 0;
    bit         go = 0;
    int         mrd [3], mwr [3], mn [3];
    bit         mact [3], movf [3];
    logic [8:0] mmem [3][256];
    int         cap [32];
    int         ncap = 0, cap_i = 0;

    always #5 clk = ~clk;

    outbuf_drain #(.WORDLEN(8), .BUFSIZE(10), .SKIP(2), .FRAMELEN(4)) u0 (
        .clk(clk), .rstn(rstn), .start(start), .in_valid(in_valid), .din(din), .out_ready(out_ready),
        .out_valid(ov_w[0]), .dout(dout_w[0]), .out_last(last_w[0]), .empty(empty_w[0]), .full(full_w[0]),
        .count(cnt_w[0]), .busy(busy_w[0]), .overflow(ovf_w[0]));
    outbuf_drain #(.WORDLEN(8), .BUFSIZE(4), .SKIP(0), .FRAMELEN(6)) u1 (
        .clk(clk), .rstn(rstn), .start(start), .in_valid(in_valid), .din(din), .out_ready(out_ready),
        .out_valid(ov_w[1]), .dout(dout_w[1]), .out_last(last_w[1]), .empty(empty_w[1]), .full(full_w[1]),
        .count(cnt_w[1]), .busy(busy_w[1]), .overflow(ovf_w[1]));
    outbuf_drain #(.WORDLEN(8), .BUFSIZE(4), .SKIP(0), .FRAMELEN(3)) u2 (
        .clk(clk), .rstn(rstn), .start(start), .in_valid(in_valid), .din(din), .out_ready(out_ready),
        .out_valid(ov_w[2]), .dout(dout_w[2]), .out_last(last_w[2]), .empty(empty_w[2]), .full(full_w[2]),
        .count(cnt_w[2]), .busy(busy_w[2]), .overflow(ovf_w[2]));

    task automatic check(input string nm, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    // frame model: the n-th accepted strobe after start is skipped, stored, or ignored by position alone
    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            int occ;
            bit pop;
            if (!rstn) begin
                mrd[i] = 0; mwr[i] = 0; mn[i] = 0; mact[i] = 0; movf[i] = 0;
            end else begin
                occ = mwr[i] - mrd[i];
                pop = occ > 0 && out_ready;
                if (start) begin
                    mact[i] = 1; mn[i] = 0; movf[i] = 0;
                end else if (mact[i] && in_valid && mn[i] < PS[i] + PF[i]) begin
                    if (mn[i] >= PS[i]) begin
                        if (occ < PB[i] || pop) begin
                            mmem[i][mwr[i] % 256] = {din, 1'(mn[i] - PS[i] == PF[i] - 1)};
                            mwr[i]++;
                        end else movf[i] = 1;
                    end
                    mn[i]++;
                end
                if (pop) mrd[i]++;
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 3; i++) begin
            int occ;
            occ = mwr[i] - mrd[i];
            check($sformatf("u%0d out_valid", i), ov_w[i], int'(occ > 0));
            check($sformatf("u%0d empty", i), empty_w[i], int'(occ == 0));
            check($sformatf("u%0d full", i), full_w[i], int'(occ == PB[i]));
            check($sformatf("u%0d count", i), cnt_w[i], occ);
            check($sformatf("u%0d busy", i), busy_w[i], int'(mact[i] && mn[i] < PS[i] + PF[i]));
            check($sformatf("u%0d overflow", i), ovf_w[i], int'(movf[i]));
            if (occ > 0) begin
                check($sformatf("u%0d dout", i), dout_w[i], int'(mmem[i][mrd[i] % 256][8:1]));
                check($sformatf("u%0d out_last", i), last_w[i], int'(mmem[i][mrd[i] % 256][0]));
            end
        end
    endtask

    task automatic step(input logic s, input logic v, input logic [7:0] d, input logic r);
        start = s; in_valid = v; din = d; out_ready = r;
        if (ov_w[cap_i] === 1'b1 && r && ncap < 32) begin
            cap[ncap] = int'(dout_w[cap_i]);
            ncap++;
        end
        model_step();
        @(posedge clk);
        #1;
        if (go) compare_all();
    endtask

    initial begin
        int c;
        rstn = 0;
        step(0, 0, 0, 0);
        go = 1;
        step(0, 0, 0, 0);
        check("rst out_valid", ov_w[0], 0);
        check("rst dout", dout_w[0], 0);
        check("rst out_last", last_w[0], 0);
        check("rst empty", empty_w[0], 1);
        check("rst busy", busy_w[0], 0);
        check("rst count", cnt_w[1], 0);
        // skip two, pass four, consumer always ready
        rstn = 1; cap_i = 0; ncap = 0;
        step(1, 0, 0, 1);
        for (int k = 1; k <= 6; k++) begin
            step(0, 1, 8'(k), 1);
            if (k == 5) begin
                check("A busy mid", busy_w[0], 1);
                check("A last on 5", last_w[0], 0);
            end
            if (k == 6) begin
                check("A dout 6", dout_w[0], 6);
                check("A last on 6", last_w[0], 1);
                check("A busy end", busy_w[0], 0);
            end
        end
        step(0, 0, 0, 1);
        check("A n words", ncap, 4);
        for (int j = 0; j < 4; j++) check($sformatf("A word%0d", j), cap[j], j + 3);
        check("A empty", empty_w[0], 1);
        rstn = 0;
        step(0, 0, 0, 0);
        rstn = 1;
        // overflow: six words into a four-deep FIFO with no consumer
        step(1, 0, 0, 0);
        for (int k = 0; k < 6; k++) begin
            step(0, 1, 8'(10 + k), 0);
            if (k == 3) begin
                check("B full at 4", full_w[1], 1);
                check("B ovf at 4", ovf_w[1], 0);
            end
        end
        check("B full", full_w[1], 1);
        check("B count", cnt_w[1], 4);
        check("B overflow", ovf_w[1], 1);
        check("B busy", busy_w[1], 0);
        check("B head", dout_w[1], 10);
        // push and pop together while full
        step(1, 0, 0, 0);
        check("C ovf cleared", ovf_w[1], 0);
        check("C count kept", cnt_w[1], 4);
        step(0, 1, 20, 1);
        check("C count", cnt_w[1], 4);
        check("C head", dout_w[1], 11);
        check("C overflow", ovf_w[1], 0);
        cap_i = 1; ncap = 0;
        for (int k = 0; k < 4; k++) step(0, 0, 0, 1);
        check("C n words", ncap, 4);
        check("C w0", cap[0], 11);
        check("C w1", cap[1], 12);
        check("C w2", cap[2], 13);
        check("C w3", cap[3], 20);
        check("C empty", empty_w[1], 1);
        // strobe coincident with start is ignored
        step(1, 1, 99, 0);
        check("D start count", cnt_w[1], 0);
        check("D start busy", busy_w[1], 1);
        step(0, 1, 50, 0);
        check("D count", cnt_w[1], 1);
        check("D head", dout_w[1], 50);
        check("D skip count", cnt_w[0], 0);
        // reset mid-frame beats start, strobe and ready
        step(0, 1, 51, 0);
        step(0, 1, 52, 0);
        check("E count 3", cnt_w[1], 3);
        check("E busy", busy_w[1], 1);
        rstn = 0;
        step(1, 1, 77, 1);
        check("E rst count", cnt_w[1], 0);
        check("E rst empty", empty_w[1], 1);
        check("E rst out_valid", ov_w[1], 0);
        check("E rst busy", busy_w[1], 0);
        check("E rst dout", dout_w[1], 0);
        rstn = 1;
        // three short frames with a consumer ready every other cycle
        cap_i = 2; ncap = 0; c = 0;
        for (int f = 0; f < 3; f++) begin
            step(1, 0, 0, 1'(c % 2)); c++;
            for (int w = 0; w < 3; w++) begin
                step(0, 1, 8'(f * 3 + w + 1), 1'(c % 2)); c++;
            end
        end
        check("F peak count", cnt_w[2], 4);
        check("F overflow", ovf_w[2], 0);
        for (int k = 0; k < 20 && empty_w[2] !== 1'b1; k++) begin
            step(0, 0, 0, 1'(c % 2)); c++;
        end
        check("F empty", empty_w[2], 1);
        check("F n words", ncap, 9);
        for (int j = 0; j < 9; j++) check($sformatf("F word%0d", j), cap[j], j + 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/outbuf_drain.md
OUTBUF_DRAIN -- requirements
Module: outbuf_drain

Interface
REQ-001 Parameter WORDLEN, default 8, result word width in bits.
REQ-002 Parameter BUFSIZE, default 10, FIFO depth in words; legal range 2..31.
REQ-003 Parameter SKIP, default 0, leading words discarded per frame (systolic skew/padding); legal range 0..31.
REQ-004 Parameter FRAMELEN, default 4, words stored per frame; legal range 1..255.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rstn  input  1  reset, synchronous, active-low.
REQ-007 start  input  1  single-cycle pulse that begins a new frame.
REQ-008 in_valid  input  1  PE-array column output strobe; no back-pressure toward the array.
REQ-009 din  input  WORDLEN  PE-array column result word.
REQ-010 out_ready  input  1  downstream consumer accepts dout this cycle.
REQ-011 out_valid  output  1  dout/out_last hold a valid word.
REQ-012 dout  output  WORDLEN  word at FIFO head (show-ahead).
REQ-013 out_last  output  1  head word is the final word of its frame.
REQ-014 empty  output  1  FIFO holds 0 words.
REQ-015 full  output  1  FIFO holds BUFSIZE words.
REQ-016 count  output  6  FIFO occupancy, 0..BUFSIZE.
REQ-017 busy  output  1  FSM in SKIP or PASS.
REQ-018 overflow  output  1  sticky; a word was dropped because the FIFO was full.

Function
REQ-019 FSM states: IDLE, SKIP, PASS; busy = (state != IDLE).
REQ-020 IDLE: in_valid ignored; stays IDLE until start.
REQ-021 start in any state: next state SKIP with skip counter = SKIP, or PASS when SKIP == 0; frame counter cleared; overflow cleared; FIFO contents untouched.
REQ-022 An in_valid coincident with start is ignored.
REQ-023 SKIP: each in_valid discards din and decrements the skip counter; when the counter reaches 1 and in_valid occurs, the next state is PASS.
REQ-024 PASS: each in_valid is a frame word; frame counter increments; on the FRAMELEN-th word, the word is tagged last and the next state is IDLE.
REQ-025 Push = PASS && in_valid && !start && (!full || pop); pushed entry = {din, last tag}.
REQ-026 Pop = out_valid && out_ready; head advances one entry.
REQ-027 out_valid = !empty; dout and out_last are combinational from the head entry; zero-cycle read latency.
REQ-028 Input-to-output latency: a word pushed at edge N is visible on dout after edge N when the FIFO was empty.
REQ-029 Head and tail pointers wrap from BUFSIZE-1 to 0.
REQ-030 Push and pop in the same cycle: both occur; count unchanged; legal when full.
REQ-031 Push and pop in the same cycle with empty: push only; the pop is not possible because out_valid = 0.
REQ-032 PASS && in_valid && full && !pop: word dropped, overflow set to 1, frame counter still advances.
REQ-033 If the dropped word is the FRAMELEN-th word, the FSM still goes to IDLE; no last tag is stored.
REQ-034 out_ready while empty has no effect; count never underflows.
REQ-035 dout is held stable while out_valid && !out_ready.

Reset
REQ-036 rstn low at a rising edge sets: state IDLE; pointers, count, skip counter and frame counter to 0; all FIFO entries to 0.
REQ-037 Reset output values: out_valid 0, dout 0, out_last 0, empty 1, full 0, count 0, busy 0, overflow 0.
REQ-038 Reset asserted mid-frame aborts the frame, discards buffered words, and takes priority over start, in_valid and out_ready.

Verification
REQ-039 SKIP=2, FRAMELEN=4, start, then in_valid for 6 cycles with din 1..6, out_ready=1 -> dout sequence 3,4,5,6; out_last high only with 6; busy low after the 6th word.
REQ-040 BUFSIZE=4, SKIP=0, FRAMELEN=6, out_ready=0, 6 words 10..15 -> full after 4; overflow=1; count=4; FIFO holds 10..13; state IDLE.
REQ-041 BUFSIZE=4, full, in_valid and out_ready in the same cycle -> count stays 4; head word popped; new word stored; overflow stays 0.
REQ-042 Wrap: BUFSIZE=4, 3 frames of FRAMELEN=3, out_ready toggling every cycle -> all 9 words out in order; pointers wrap; empty=1 at end.
REQ-043 start with in_valid in the same cycle -> that word is not skipped-counted or stored; counting begins the next cycle.
REQ-044 rstn low while count=3 and state PASS -> next cycle count=0, empty=1, out_valid=0, busy=0, dout=0.
